// File: rtl/toy_fetch_slicer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_slicer_pkg
// Brief    : Shared types and sizing for the fetch slicer and its neighbours.
//            The ROB and the slicer both take their payload width from here,
//            so the two ends of the filter interface cannot disagree.
// Revision : 1.0 - initial release
// ============================================================================
package toy_fetch_slicer_pkg;

  // Geometry of a fetch packet and of the decode group
  localparam int FETCH_SLOTS = 8;
  localparam int DEC_WIDTH   = 4;
  localparam int INST_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;

  // Derived widths
  localparam int SLOT_W = $clog2(FETCH_SLOTS);
  // The cursor has to reach FETCH_SLOTS (one past the last slot)
  localparam int CUR_W  = SLOT_W + 1;
  // Remaining-slot arithmetic keeps a guard bit so end-cur+1 never wraps
  // while a packet is live
  localparam int REM_W  = SLOT_W + 2;
  // Lane count ranges 0..DEC_WIDTH inclusive
  localparam int LANE_W = $clog2(DEC_WIDTH) + 1;

  // Byte offset covered by one whole packet (slots * 4 bytes)
  localparam int PKT_OFS_W = SLOT_W + 2;

  typedef logic [FETCH_SLOTS-1:0][INST_WIDTH-1:0] inst_arr_t;
  typedef logic [DEC_WIDTH-1:0][INST_WIDTH-1:0]   lane_arr_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [SLOT_W-1:0]     start_slot;
    logic [SLOT_W-1:0]     end_slot;
    inst_arr_t             insts;
  } fetch_pkt_t;

  localparam int FETCH_DATA_WIDTH = $bits(fetch_pkt_t);

  // Packet-aligned base PC: slot index and byte offset bits cleared
  function automatic logic [ADDR_WIDTH-1:0] pkt_base(input logic [ADDR_WIDTH-1:0] pc);
    return pc & ~ADDR_WIDTH'((1 << PKT_OFS_W) - 1);
  endfunction

  // Number of lanes in the next group: min(remain, DEC_WIDTH)
  function automatic logic [LANE_W-1:0] lane_count(input logic [REM_W-1:0] remain);
    if (remain > REM_W'(DEC_WIDTH)) begin
      return LANE_W'(DEC_WIDTH);
    end
    return remain[LANE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/toy_fetch_slot_mux.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_slot_mux
// Brief    : Rotates the instruction slots of a held fetch packet so that the
//            slot under the cursor lands in decode lane 0. Purely
//            combinational.
// Revision : 1.0 - initial release
// ============================================================================
module toy_fetch_slot_mux
  import toy_fetch_slicer_pkg::*;
(
  input  inst_arr_t         insts,
  input  logic [SLOT_W-1:0] cur,
  output lane_arr_t         lanes
);

  // Lane i reads slot cur+i; the index wraps within the packet, and lanes
  // past the end of the packet are masked by the caller's valid bits
  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_lane
    logic [SLOT_W-1:0] slot;
    assign slot     = cur + SLOT_W'(i);
    assign lanes[i] = insts[slot];
  end

endmodule
`default_nettype wire

// File: rtl/toy_fetch_slicer.sv
`default_nettype none
// ============================================================================
// Module   : toy_fetch_slicer
// Brief    : Holds one in-order fetch packet from the ROB and hands its valid
//            slots to the decoder in groups of up to DEC_WIDTH contiguous
//            instructions per cycle. A front-end flush drops everything.
// Revision : 1.0 - initial release
// ============================================================================
module toy_fetch_slicer
  import toy_fetch_slicer_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             filter_vld,
  output logic                             filter_rdy,
  input  logic [FETCH_DATA_WIDTH-1:0]      filter_pld,
  input  logic                             fe_ctrl_flush,
  output logic [DEC_WIDTH-1:0]             dec_vld,
  output logic [DEC_WIDTH*INST_WIDTH-1:0]  dec_inst,
  output logic [DEC_WIDTH*ADDR_WIDTH-1:0]  dec_pc,
  output logic                             dec_last,
  input  logic                             dec_rdy
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                  busy;
  logic [CUR_W-1:0]      cur;
  // The start slot only seeds the cursor, so the held packet keeps just the
  // fields the group logic still needs
  logic [ADDR_WIDTH-1:0] pkt_pc;
  logic [SLOT_W-1:0]     pkt_end;
  inst_arr_t             pkt_insts;

  // --------------------------------------------------------------------------
  // Incoming packet view
  // --------------------------------------------------------------------------
  fetch_pkt_t in_pkt;
  logic       in_empty;

  assign in_pkt   = fetch_pkt_t'(filter_pld);
  assign in_empty = (in_pkt.start_slot > in_pkt.end_slot);

  // --------------------------------------------------------------------------
  // Group sizing
  // --------------------------------------------------------------------------
  // While rst is held the outputs already show the idle state, even if the
  // registers still carry a packet from before the reset
  logic              live;
  logic [REM_W-1:0]  remain;
  logic [LANE_W-1:0] n_lanes;
  logic              fire;
  logic              accept;
  logic [ADDR_WIDTH-1:0] base_pc;

  assign live     = busy & ~rst;
  assign remain   = REM_W'(pkt_end) - REM_W'(cur) + REM_W'(1);
  assign n_lanes  = lane_count(remain);
  assign dec_last = live && (remain <= REM_W'(DEC_WIDTH));
  assign fire     = (|dec_vld) & dec_rdy;

  // Refill in the same cycle the last group leaves, so packets flow with no
  // bubble; independent of filter_vld
  assign filter_rdy = ~live | (fire & dec_last);
  // A packet offered during a flush completes the handshake but is dropped
  assign accept     = filter_vld & filter_rdy & ~fe_ctrl_flush;

  assign base_pc = pkt_base(pkt_pc);

  // --------------------------------------------------------------------------
  // Lane formation
  // --------------------------------------------------------------------------
  lane_arr_t mux_lanes;

  toy_fetch_slot_mux u_slot_mux (
    .insts (pkt_insts),
    .cur   (cur[SLOT_W-1:0]),
    .lanes (mux_lanes)
  );

  // Valid lanes form a low-order run; inactive lanes drive zero data and PC
  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_dec_lane
    logic [ADDR_WIDTH-1:0] lane_pc;

    assign lane_pc    = base_pc + ((ADDR_WIDTH'(cur) + ADDR_WIDTH'(i)) << 2);
    assign dec_vld[i] = live && (n_lanes > LANE_W'(i));
    assign dec_inst[i*INST_WIDTH +: INST_WIDTH] = dec_vld[i] ? mux_lanes[i] : '0;
    assign dec_pc[i*ADDR_WIDTH +: ADDR_WIDTH]   = dec_vld[i] ? lane_pc : '0;
  end

  // --------------------------------------------------------------------------
  // Packet / cursor state: reset, then flush, then group advance and refill
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      cur       <= '0;
      pkt_pc    <= '0;
      pkt_end   <= '0;
      pkt_insts <= '0;
    end else if (fe_ctrl_flush) begin
      busy <= 1'b0;
      cur  <= '0;
    end else begin
      if (fire) begin
        cur <= cur + CUR_W'(n_lanes);
        if (dec_last) begin
          busy <= 1'b0;
        end
      end
      // Acceptance only happens when idle or on the final group, so it can
      // safely override the advance above; an empty packet leaves busy low
      if (accept) begin
        pkt_pc    <= in_pkt.pc;
        pkt_end   <= in_pkt.end_slot;
        pkt_insts <= in_pkt.insts;
        cur       <= CUR_W'(in_pkt.start_slot);
        busy      <= ~in_empty;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_toy_fetch_slicer.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_fetch_slicer
// Brief    : Directed self-checking bench for toy_fetch_slicer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_fetch_slicer;
  import toy_fetch_slicer_pkg::*;

  logic                            clk;
  logic                            rst;
  logic                            filter_vld;
  logic                            filter_rdy;
  fetch_pkt_t                      pld;
  logic                            fe_ctrl_flush;
  logic [DEC_WIDTH-1:0]            dec_vld;
  logic [DEC_WIDTH*INST_WIDTH-1:0] dec_inst;
  logic [DEC_WIDTH*ADDR_WIDTH-1:0] dec_pc;
  logic                            dec_last;
  logic                            dec_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  toy_fetch_slicer dut (
    .clk           (clk),
    .rst           (rst),
    .filter_vld    (filter_vld),
    .filter_rdy    (filter_rdy),
    .filter_pld    (pld),
    .fe_ctrl_flush (fe_ctrl_flush),
    .dec_vld       (dec_vld),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .dec_last      (dec_last),
    .dec_rdy       (dec_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot k of packet id holds 0xA000_<id><k>
  function automatic fetch_pkt_t mk(input logic [31:0] pc, input int s, input int e,
                                    input logic [7:0] id);
    fetch_pkt_t p;
    p.pc         = pc;
    p.start_slot = SLOT_W'(s);
    p.end_slot   = SLOT_W'(e);
    for (int k = 0; k < FETCH_SLOTS; k++) begin
      p.insts[k] = 32'hA000_0000 | (32'(id) << 8) | 32'(k);
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    filter_vld    = 1'b0;
    fe_ctrl_flush = 1'b0;
    dec_rdy       = 1'b0;
    pld           = '0;
    nxt();
    nxt();

    // ---- reset state
    at_neg();
    chk("rst_vld",  dec_vld,    0);
    chk("rst_last", dec_last,   0);
    chk("rst_rdy",  filter_rdy, 1);
    chk("rst_pc",   dec_pc,     0);
    chk("rst_inst", dec_inst,   0);
    nxt();
    rst = 1'b0;

    // ---- 1: full packet, two groups
    pld = mk(32'h1000, 0, 7, 8'h1); filter_vld = 1'b1; dec_rdy = 1'b1;
    at_neg();
    chk("t1_rdy_idle", filter_rdy, 1);
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t1_g0_vld",  dec_vld,  4'hF);
    chk("t1_g0_pc",   dec_pc,   128'h0000100C_00001008_00001004_00001000);
    chk("t1_g0_inst", dec_inst, 128'hA0000103_A0000102_A0000101_A0000100);
    chk("t1_g0_last", dec_last, 0);
    chk("t1_g0_rdy",  filter_rdy, 0);
    nxt();
    at_neg();
    chk("t1_g1_vld",  dec_vld,  4'hF);
    chk("t1_g1_pc",   dec_pc,   128'h0000101C_00001018_00001014_00001010);
    chk("t1_g1_inst", dec_inst, 128'hA0000107_A0000106_A0000105_A0000104);
    chk("t1_g1_last", dec_last, 1);
    chk("t1_g1_rdy",  filter_rdy, 1);
    nxt();
    at_neg();
    chk("t1_done_vld", dec_vld, 0);
    nxt();

    // ---- 2: partial packet, slots 5..6
    pld = mk(32'h1000, 5, 6, 8'h2); filter_vld = 1'b1;
    at_neg();
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t2_vld",  dec_vld,  4'b0011);
    chk("t2_pc",   dec_pc,   128'h00000000_00000000_00001018_00001014);
    chk("t2_inst", dec_inst, 128'h00000000_00000000_A0000206_A0000205);
    chk("t2_last", dec_last, 1);
    chk("t2_rdy",  filter_rdy, 1);
    nxt();
    at_neg();
    chk("t2_done_vld", dec_vld, 0);
    nxt();

    // ---- 3: back-to-back packets, no idle cycle
    pld = mk(32'h2000, 0, 7, 8'h3); filter_vld = 1'b1;
    at_neg();
    nxt(); pld = mk(32'h3000, 2, 4, 8'h4);
    at_neg();
    chk("t3_a0_pc",  dec_pc,     128'h0000200C_00002008_00002004_00002000);
    chk("t3_a0_rdy", filter_rdy, 0);
    nxt();
    at_neg();
    chk("t3_a1_pc",   dec_pc,     128'h0000201C_00002018_00002014_00002010);
    chk("t3_a1_last", dec_last,   1);
    chk("t3_a1_rdy",  filter_rdy, 1);
    nxt(); pld = mk(32'h4000, 4, 7, 8'h5);
    at_neg();
    chk("t3_b_vld",  dec_vld,    4'b0111);
    chk("t3_b_pc",   dec_pc,     128'h00000000_00003010_0000300C_00003008);
    chk("t3_b_inst", dec_inst,   128'h00000000_A0000404_A0000403_A0000402);
    chk("t3_b_last", dec_last,   1);
    chk("t3_b_rdy",  filter_rdy, 1);
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t3_c_vld",  dec_vld,  4'hF);
    chk("t3_c_pc",   dec_pc,   128'h0000401C_00004018_00004014_00004010);
    chk("t3_c_inst", dec_inst, 128'hA0000507_A0000506_A0000505_A0000504);
    chk("t3_c_last", dec_last, 1);
    nxt();
    at_neg();
    chk("t3_done_vld", dec_vld, 0);
    nxt();

    // ---- 4: backpressure mid-packet, new packet offered during the stall
    pld = mk(32'h5000, 0, 7, 8'h6); filter_vld = 1'b1;
    at_neg();
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t4_g0_pc", dec_pc, 128'h0000500C_00005008_00005004_00005000);
    nxt();
    dec_rdy = 1'b0; pld = mk(32'h6000, 0, 0, 8'h7); filter_vld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("t4_stall_vld",  dec_vld,    4'hF);
      chk("t4_stall_pc",   dec_pc,     128'h0000501C_00005018_00005014_00005010);
      chk("t4_stall_inst", dec_inst,   128'hA0000607_A0000606_A0000605_A0000604);
      chk("t4_stall_last", dec_last,   1);
      chk("t4_stall_rdy",  filter_rdy, 0);
      nxt();
    end
    dec_rdy = 1'b1;
    at_neg();
    chk("t4_release_pc",  dec_pc,     128'h0000501C_00005018_00005014_00005010);
    chk("t4_release_rdy", filter_rdy, 1);
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t4_x_vld",  dec_vld,  4'b0001);
    chk("t4_x_pc",   dec_pc,   128'h00000000_00000000_00000000_00006000);
    chk("t4_x_inst", dec_inst, 128'h00000000_00000000_00000000_A0000700);
    chk("t4_x_last", dec_last, 1);
    nxt();
    at_neg();
    chk("t4_done_vld", dec_vld, 0);
    nxt();

    // ---- 5: flush while busy at cur=4, packet offered in the same cycle
    pld = mk(32'h7000, 0, 7, 8'h8); filter_vld = 1'b1;
    at_neg();
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t5_g0_pc", dec_pc, 128'h0000700C_00007008_00007004_00007000);
    nxt();
    fe_ctrl_flush = 1'b1; filter_vld = 1'b1; pld = mk(32'h8000, 0, 3, 8'h9);
    at_neg();
    chk("t5_flush_vld", dec_vld,    4'hF);
    chk("t5_flush_pc",  dec_pc,     128'h0000701C_00007018_00007014_00007010);
    chk("t5_flush_rdy", filter_rdy, 1);
    nxt(); fe_ctrl_flush = 1'b0; filter_vld = 1'b0;
    at_neg();
    chk("t5_post_vld",  dec_vld,    0);
    chk("t5_post_last", dec_last,   0);
    chk("t5_post_rdy",  filter_rdy, 1);
    nxt();
    at_neg();
    chk("t5_post2_vld", dec_vld, 0);
    nxt();

    // ---- 6: empty packet followed by a single-slot packet
    pld = mk(32'h9000, 3, 2, 8'hA); filter_vld = 1'b1;
    at_neg();
    nxt(); pld = mk(32'hA000, 0, 0, 8'hB);
    at_neg();
    chk("t6_empty_vld", dec_vld,    0);
    chk("t6_empty_rdy", filter_rdy, 1);
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t6_v_vld",  dec_vld,  4'b0001);
    chk("t6_v_pc",   dec_pc,   128'h00000000_00000000_00000000_0000A000);
    chk("t6_v_inst", dec_inst, 128'h00000000_00000000_00000000_A0000B00);
    chk("t6_v_last", dec_last, 1);
    nxt();
    at_neg();
    chk("t6_done_vld", dec_vld, 0);
    nxt();

    // ---- 7: single slot at the top of the packet, unaligned incoming pc
    pld = mk(32'hB004, 7, 7, 8'hC); filter_vld = 1'b1;
    at_neg();
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t7_vld",  dec_vld,  4'b0001);
    chk("t7_pc",   dec_pc,   128'h00000000_00000000_00000000_0000B01C);
    chk("t7_inst", dec_inst, 128'h00000000_00000000_00000000_A0000C07);
    chk("t7_last", dec_last, 1);
    nxt();

    // ---- 8: reset mid-packet
    pld = mk(32'hC000, 0, 7, 8'hD); filter_vld = 1'b1; dec_rdy = 1'b0;
    at_neg();
    nxt(); filter_vld = 1'b0;
    at_neg();
    chk("t8_held_vld", dec_vld, 4'hF);
    nxt(); rst = 1'b1;
    at_neg();
    chk("t8_inrst_vld", dec_vld,    0);
    chk("t8_inrst_rdy", filter_rdy, 1);
    nxt(); rst = 1'b0; dec_rdy = 1'b1;
    at_neg();
    chk("t8_post_vld", dec_vld,    0);
    chk("t8_post_rdy", filter_rdy, 1);
    chk("t8_post_pc",  dec_pc,     0);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
